// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, NOP encoding, fetch FSM states.
package pipe_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTN = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; low two address bits are always dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// PC register: redirect load (aligned) beats increment beats hold.
module pc_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc,
  output logic [31:0] pc_nxt
);

  // Next PC; exported so the fetch FSM can start a request at it.
  always_comb begin
    pc_nxt = pc;
    if (load)     pc_nxt = align_pc(load_pc);
    else if (inc) pc_nxt = pc + PC_STEP;
  end

  // PC state, wraps mod 2^32.
  always_ff @(posedge clk) begin
    if (rst) pc <= align_pc(RESET_PC);
    else     pc <= pc_nxt;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding IF/ID: owns the PC, talks req/ack to imem,
// buffers a word across a stall, and discards stale data after a redirect.
module if_fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_instn,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pcplus4,
  output logic            if_valid
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc, pc_nxt, req_addr, buf_instn, buf_pc;
  logic            pc_inc;

  // Advance the PC only when a word actually moves to the outputs.
  always_comb begin
    pc_inc = 1'b0;
    if (!redirect && !stall)
      pc_inc = (state == FETCH && imem_ack) || (state == HOLD);
  end

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc),
    .pc_nxt  (pc_nxt)
  );

  // HOLD is the only state without a request in flight; reset kills it at once.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = req_addr;

  // Fetch FSM plus IF/ID output registers and the one-entry skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      req_addr   <= align_pc(RESET_PC);
      buf_instn  <= NOP_INSTN;
      buf_pc     <= '0;
      if_valid   <= 1'b0;
      if_instn   <= NOP_INSTN;
      if_pc      <= '0;
      if_pcplus4 <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if_instn <= NOP_INSTN;
            // Acked word is dropped; otherwise the old request must drain.
            if (imem_ack) req_addr <= pc_nxt;
            else          state    <= DRAIN;
          end else if (imem_ack) begin
            if (!stall) begin
              if_valid   <= 1'b1;
              if_instn   <= imem_rdata;
              if_pc      <= pc;
              if_pcplus4 <= pc + PC_STEP;
              req_addr   <= pc_nxt;
            end else begin
              buf_instn <= imem_rdata;
              buf_pc    <= pc;
              state     <= HOLD;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_instn <= NOP_INSTN;
          end
        end
        HOLD: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if_instn <= NOP_INSTN;
            state    <= FETCH;
            req_addr <= pc_nxt;
          end else if (!stall) begin
            if_valid   <= 1'b1;
            if_instn   <= buf_instn;
            if_pc      <= buf_pc;
            if_pcplus4 <= buf_pc + PC_STEP;
            state      <= FETCH;
            req_addr   <= pc_nxt;
          end
        end
        DRAIN: begin
          if (redirect || !stall) begin
            if_valid <= 1'b0;
            if_instn <= NOP_INSTN;
          end
          // Stale response arrives: throw it away and start at the live PC.
          if (imem_ack) begin
            state    <= FETCH;
            req_addr <= pc_nxt;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC and issues word requests to an instruction memory over a req/ack handshake. Produces instruction, current PC and PC+4 for IF/ID. Honours hazard-unit stall and branch/jump redirect (flush), and inserts bubbles when memory is slow.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
XLEN, 32, address/data width (only 32 supported).

Ports:
clk  in  1  pipeline clock, all state on posedge
rst  in  1  synchronous reset, active-high
stall  in  1  hazard unit: hold IF outputs, do not advance
redirect  in  1  taken branch/jump from later stage; flushes IF
redirect_pc  in  32  target PC; bits [1:0] forced to 00
imem_req  out  1  request valid; held high until imem_ack
imem_addr  out  32  request address; stable while imem_req high
imem_ack  in  1  read data valid this cycle (may be same cycle as req)
imem_rdata  in  32  instruction word, valid when imem_ack
if_instn  out  32  to IF/ID inp_instn; NOP (32'h0) when if_valid=0
if_pc  out  32  to IF/ID currpc
if_pcplus4  out  32  to IF/ID nextpc
if_valid  out  1  output holds a real instruction

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, state=FETCH, if_valid=0, if_instn=0, if_pc=0, if_pcplus4=0, skid buffer cleared. imem_req=0 while rst high. Outstanding request abandoned.
- States: FETCH (imem_req=1, imem_addr=req_addr), HOLD (fetched word buffered, imem_req=0), DRAIN (stale request outstanding, imem_req=1, ack discarded).
- req_addr loads pc whenever a new request starts (entry to FETCH); unchanged in DRAIN.
- FETCH, ack, stall=0, no redirect: outputs <= {imem_rdata, pc, pc+4}, if_valid<=1, pc<=pc+4, stay FETCH. Zero-latency memory gives 1 instruction/cycle.
- FETCH, ack, stall=1: buffer {rdata, pc}; outputs hold; -> HOLD.
- FETCH, no ack: stall=0 -> bubble (if_valid<=0, if_instn<=0); stall=1 -> outputs hold.
- HOLD, stall=0: outputs <= buffer, if_valid<=1, pc<=pc+4, -> FETCH. HOLD, stall=1: stay, outputs hold.
- redirect=1 overrides stall in every state: pc<=redirect_pc & ~3, if_valid<=0, if_instn<=0, if_pc/if_pcplus4 hold.
  FETCH+ack -> ack discarded, stay FETCH, new request next cycle. FETCH no ack -> DRAIN. HOLD -> buffer dropped, -> FETCH. DRAIN -> pc updated (latest redirect wins), stay DRAIN unless ack.
- DRAIN: on ack discard data, -> FETCH with new pc. Outputs: bubble if stall=0, hold if stall=1.
- PC arithmetic mod 2^32: pc=FFFF_FFFC gives if_pcplus4=0000_0000, next fetch addr 0.
- imem_ack while imem_req=0 ignored. Each fetched word delivered exactly once; no skipped PCs.

Decomposition:
- Shared package pipe_pkg: XLEN, NOP_INSTN=32'h0000_0000, fetch state enum {FETCH, HOLD, DRAIN}, PC_STEP=4.
- One sub-module: pc_reg (PC register with load-redirect / increment / hold, alignment masking, RESET_PC).

Test Plan:
- RESET_PC=0x0040_0000, zero-latency memory returning rdata=addr^0xA5A5_A5A5, release rst -> after 1st edge if_valid=1, if_pc=0x0040_0000, if_pcplus4=0x0040_0004; then 0x0040_0004, 0x0040_0008 on consecutive cycles.
- Stall 3 cycles on an ack -> outputs frozen, imem_req=0 in HOLD; after release buffered word appears once, next if_pc = previous+4, no duplicates.
- redirect=1, redirect_pc=0x0000_1003, coincident with ack -> next cycle if_valid=0, if_instn=0; next imem_addr=0x0000_1000; acked word never reaches outputs.
- 3-cycle-latency memory, redirect to 0x2000 mid-request -> imem_addr holds old value until ack (DRAIN), stale data dropped, next request 0x2000.
- redirect_pc=0xFFFF_FFFC -> if_pcplus4=0x0000_0000, following fetch at 0x0000_0000.
- redirect and stall same cycle -> flush wins (if_valid=0); rst asserted during DRAIN -> next cycle all outputs at reset values, imem_req=0.
